// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: two-flop synchronizer, mid-bit sampling FSM and a
// 2-entry receive FIFO with sticky frame-error and overrun flags.
module uart_rx_core #(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk_in,
  input  logic                 reset,
  input  logic                 en_i,
  input  logic [DIV_WIDTH-1:0] clk_div_i,
  input  logic                 uart_rx,
  output logic [7:0]           data_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [1:0]           level_o,
  output logic                 frame_err_o,
  output logic                 overrun_o,
  input  logic                 clear_i
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  // Output handshake: a byte leaves the FIFO on a rising edge where
  // valid_o and ready_i are both 1; data_o is the head while valid_o=1.

  state_e               state_q, state_d;
  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic [2:0]           idx_q, idx_d;
  logic [7:0]           shift_q, shift_d;
  logic                 rx_meta_q, rx_s_q;
  logic [7:0]           mem0_q, mem0_d, mem1_q, mem1_d;
  logic [1:0]           level_q, level_d;
  logic                 ferr_q, ferr_d, ovr_q, ovr_d;
  logic                 push, frame_set, ovr_set, pop;
  logic [DIV_WIDTH-1:0] div_c;

  assign div_c = (clk_div_i < DIV_WIDTH'(4)) ? DIV_WIDTH'(4) : clk_div_i;

  always_ff @(posedge clk_in) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      state_q   <= IDLE;
      cnt_q     <= '0;
      div_q     <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      mem0_q    <= '0;
      mem1_q    <= '0;
      level_q   <= '0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      rx_meta_q <= uart_rx;
      rx_s_q    <= rx_meta_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      mem0_q    <= mem0_d;
      mem1_q    <= mem1_d;
      level_q   <= level_d;
      ferr_q    <= ferr_d;
      ovr_q     <= ovr_d;
    end
  end

  // Receive FSM: cnt counts down to the next mid-bit sample point.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    div_d     = div_q;
    idx_d     = idx_q;
    shift_d   = shift_q;
    push      = 1'b0;
    frame_set = 1'b0;
    if (!en_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (!rx_s_q) begin
            div_d   = div_c;
            cnt_d   = div_c >> 1;
            state_d = START;
          end
        end
        START: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - DIV_WIDTH'(1);
          end else if (!rx_s_q) begin
            cnt_d   = div_q - DIV_WIDTH'(1);
            idx_d   = '0;
            state_d = DATA;
          end else begin
            state_d = IDLE;
          end
        end
        DATA: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - DIV_WIDTH'(1);
          end else begin
            shift_d[idx_q] = rx_s_q;
            cnt_d          = div_q - DIV_WIDTH'(1);
            idx_d          = idx_q + 3'd1;
            if (idx_q == 3'd7) state_d = STOP;
          end
        end
        STOP: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - DIV_WIDTH'(1);
          end else begin
            push      = rx_s_q;
            frame_set = !rx_s_q;
            state_d   = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // FIFO: mem0 is always the head; mem1 holds the second entry.
  assign pop = (level_q != 2'd0) && ready_i;

  always_comb begin
    mem0_d  = mem0_q;
    mem1_d  = mem1_q;
    level_d = level_q;
    ovr_set = 1'b0;
    case (level_q)
      2'd0: begin
        if (push) begin
          mem0_d  = shift_q;
          level_d = 2'd1;
        end
      end
      2'd1: begin
        if (push && pop) begin
          mem0_d = shift_q;
        end else if (push) begin
          mem1_d  = shift_q;
          level_d = 2'd2;
        end else if (pop) begin
          level_d = 2'd0;
        end
      end
      default: begin
        if (push && pop) begin
          mem0_d = mem1_q;
          mem1_d = shift_q;
        end else if (push) begin
          ovr_set = 1'b1;
        end else if (pop) begin
          mem0_d  = mem1_q;
          level_d = 2'd1;
        end
      end
    endcase
  end

  // Set wins over clear when both land in the same cycle.
  assign ferr_d = frame_set ? 1'b1 : (clear_i ? 1'b0 : ferr_q);
  assign ovr_d  = ovr_set   ? 1'b1 : (clear_i ? 1'b0 : ovr_q);

  assign data_o      = mem0_q;
  assign valid_o     = (level_q != 2'd0);
  assign level_o     = level_q;
  assign frame_err_o = ferr_q;
  assign overrun_o   = ovr_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core: serial frames are driven bit by bit and
// popped bytes are checked against a queue of expected bytes.
module tb_uart_rx_core;

  logic        clk_in = 1'b0;
  logic        reset;
  logic        en_i;
  logic [15:0] clk_div_i;
  logic        uart_rx;
  logic [7:0]  data_o;
  logic        valid_o;
  logic        ready_i;
  logic [1:0]  level_o;
  logic        frame_err_o;
  logic        overrun_o;
  logic        clear_i;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  uart_rx_core #(.DIV_WIDTH(16)) dut (
    .clk_in      (clk_in),
    .reset       (reset),
    .en_i        (en_i),
    .clk_div_i   (clk_div_i),
    .uart_rx     (uart_rx),
    .data_o      (data_o),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .level_o     (level_o),
    .frame_err_o (frame_err_o),
    .overrun_o   (overrun_o),
    .clear_i     (clear_i)
  );

  // clock/reset
  always #5 clk_in = ~clk_in;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // monitor: every accepted byte is compared against the head of exp_q
  always @(negedge clk_in) begin
    if (!reset && valid_o && ready_i) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pop_unexpected: got 0x%0h expected no byte", data_o);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (data_o !== e) begin
          errors++;
          $display("FAIL pop_data: got 0x%0h expected 0x%0h", data_o, e);
        end
      end
    end
  end

  // driver tasks; each assumes it starts 1 ns after a rising edge
  task automatic tick(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int bdiv, input logic stop);
    uart_rx = 1'b0;
    tick(bdiv);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      tick(bdiv);
    end
    uart_rx = stop;
    tick(bdiv);
    uart_rx = 1'b1;
    tick(bdiv);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    ready_i = 1'b1;
    while (level_o != 2'd0 && n < 20) begin
      tick(1);
      n++;
    end
    ready_i = 1'b0;
    check({name, "_drained"}, {30'd0, level_o}, 32'd0);
  endtask

  task automatic pulse_clear();
    clear_i = 1'b1;
    tick(1);
    clear_i = 1'b0;
  endtask

  initial begin
    reset = 1'b1; en_i = 1'b1; clk_div_i = 16'd8; uart_rx = 1'b1;
    ready_i = 1'b0; clear_i = 1'b0;
    tick(3);
    reset = 1'b0;
    tick(1);
    check("rst_valid", {31'd0, valid_o}, 32'd0);
    check("rst_level", {30'd0, level_o}, 32'd0);
    check("rst_ferr", {31'd0, frame_err_o}, 32'd0);
    check("rst_ovr", {31'd0, overrun_o}, 32'd0);
    check("rst_data", {24'd0, data_o}, 32'd0);

    // single frame held in FIFO
    tick(5);
    send_byte(8'hA5, 8, 1'b1);
    exp_q.push_back(8'hA5);
    check("a5_valid", {31'd0, valid_o}, 32'd1);
    check("a5_level", {30'd0, level_o}, 32'd1);
    check("a5_ferr", {31'd0, frame_err_o}, 32'd0);
    check("a5_ovr", {31'd0, overrun_o}, 32'd0);
    drain("a5");

    // short glitch is a false start
    uart_rx = 1'b0;
    tick(3);
    uart_rx = 1'b1;
    tick(20);
    check("glitch_level", {30'd0, level_o}, 32'd0);
    check("glitch_ferr", {31'd0, frame_err_o}, 32'd0);
    check("glitch_ovr", {31'd0, overrun_o}, 32'd0);

    // framing error at div 16, then clear
    clk_div_i = 16'd16;
    send_byte(8'h3C, 16, 1'b0);
    tick(20);
    check("fe_ferr", {31'd0, frame_err_o}, 32'd1);
    check("fe_level", {30'd0, level_o}, 32'd0);
    pulse_clear();
    check("fe_cleared", {31'd0, frame_err_o}, 32'd0);

    // overrun with three frames and no consumer
    clk_div_i = 16'd8;
    send_byte(8'h11, 8, 1'b1);
    send_byte(8'h22, 8, 1'b1);
    send_byte(8'h33, 8, 1'b1);
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    check("ovr_level", {30'd0, level_o}, 32'd2);
    check("ovr_flag", {31'd0, overrun_o}, 32'd1);
    check("ovr_ferr", {31'd0, frame_err_o}, 32'd0);
    drain("ovr");
    pulse_clear();
    check("ovr_cleared", {31'd0, overrun_o}, 32'd0);

    // push and pop in the same cycle while full
    send_byte(8'h55, 8, 1'b1);
    send_byte(8'h66, 8, 1'b1);
    exp_q.push_back(8'h55);
    exp_q.push_back(8'h66);
    exp_q.push_back(8'h44);
    check("full_level", {30'd0, level_o}, 32'd2);
    fork
      send_byte(8'h44, 8, 1'b1);
      begin
        tick(79);
        ready_i = 1'b1;
        tick(1);
        ready_i = 1'b0;
      end
    join
    check("pp_level", {30'd0, level_o}, 32'd2);
    check("pp_ovr", {31'd0, overrun_o}, 32'd0);
    drain("pp");

    // clamp: div 2 behaves as div 4
    clk_div_i = 16'd2;
    send_byte(8'hC3, 4, 1'b1);
    exp_q.push_back(8'hC3);
    check("clamp_level", {30'd0, level_o}, 32'd1);
    drain("clamp");
    clk_div_i = 16'd8;

    // reset after data bit 3, then a clean frame
    uart_rx = 1'b0;
    tick(8);
    for (int i = 0; i < 4; i++) begin
      uart_rx = ((8'h96 >> i) & 8'h01) != 8'h00;
      tick(8);
    end
    reset = 1'b1;
    uart_rx = 1'b1;
    tick(1);
    reset = 1'b0;
    tick(30);
    check("mid_rst_level", {30'd0, level_o}, 32'd0);
    check("mid_rst_valid", {31'd0, valid_o}, 32'd0);
    exp_q.push_back(8'h5A);
    ready_i = 1'b1;
    send_byte(8'h5A, 8, 1'b1);
    begin
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 200) begin
        tick(1);
        n++;
      end
    end
    ready_i = 1'b0;
    tick(2);
    check("exp_q_empty", exp_q.size(), 32'd0);
    check("final_level", {30'd0, level_o}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_core.md
UART_RX_CORE -- requirements
Module: uart_rx_core

Interface
REQ-001 SHALL have parameter DIV_WIDTH, default 16, the width of the bit-period divisor input.
REQ-002 SHALL have port clk_in, input, 1, the single clock; all logic is on its rising edge.
REQ-003 SHALL have port reset, input, 1; reset is synchronous and active-high.
REQ-004 SHALL have port en_i, input, 1; receiver enable.
REQ-005 SHALL have port clk_div_i, input, DIV_WIDTH, clk_in cycles per UART bit; a value below 4 SHALL be treated as 4.
REQ-006 SHALL have port uart_rx, input, 1; asynchronous serial line, 8N1, LSB first, idle high.
REQ-007 SHALL have port data_o, output, 8; head byte of the receive FIFO.
REQ-008 SHALL have port valid_o, output, 1; high when the FIFO is non-empty.
REQ-009 SHALL have port ready_i, input, 1; the consumer accepts the head byte.
REQ-010 SHALL have port level_o, output, 2; FIFO occupancy, 0 to 2.
REQ-011 SHALL have port frame_err_o, output, 1; sticky, set when a stop bit samples 0.
REQ-012 SHALL have port overrun_o, output, 1; sticky, set when a valid byte arrives with the FIFO full.
REQ-013 SHALL have port clear_i, input, 1; a one-cycle pulse clears frame_err_o and overrun_o.

Function
REQ-014 SHALL pass uart_rx through a two-flop synchronizer, rx_s; every sample below uses rx_s.
REQ-015 SHALL implement the FSM states IDLE, START, DATA and STOP, with a down-counter cnt of width DIV_WIDTH and a 3-bit bit index.
REQ-016 SHALL, in IDLE, when en_i=1 and rx_s=0: load cnt with div>>1 and enter START.
REQ-017 SHALL, in START, DATA and STOP, decrement cnt each cycle and take a sample in the cycle where cnt==0.
REQ-018 SHALL, at the START sample: if rx_s=0, load cnt with div-1, clear the bit index and enter DATA; if rx_s=1, treat it as a false start and return to IDLE with no flag.
REQ-019 SHALL, at each DATA sample: shift rx_s into the shift register at bit[index] (LSB first) and reload cnt with div-1; after index 7, enter STOP.
REQ-020 SHALL, at the STOP sample, if rx_s=1: push the byte into the FIFO and return to IDLE.
REQ-021 SHALL, at the STOP sample, if rx_s=0: discard the byte, set frame_err_o and return to IDLE.
REQ-022 SHALL latch div (the clamped clk_div_i) on entry to START; changes to clk_div_i mid-frame SHALL NOT affect the current frame.
REQ-023 SHALL, when en_i=0, force the FSM to IDLE within one cycle, discard any partial byte, and retain FIFO contents and flags.
REQ-024 SHALL implement the FIFO as 2 entries, first-in first-out; a pop occurs when valid_o and ready_i are both 1.
REQ-025 SHALL present data_o as the head entry whenever valid_o=1; data_o is undefined when valid_o=0.
REQ-026 SHALL make a pushed byte visible on valid_o/data_o in the cycle after the STOP sample.
REQ-027 SHALL, on a push while full with no pop in the same cycle: drop the new byte, set overrun_o, and leave FIFO contents unchanged.
REQ-028 SHALL, on a push and pop in the same cycle while full: accept the push, leave level_o at 2, and not set overrun_o.
REQ-029 SHALL, on a push and pop in the same cycle with level 1: leave level_o at 1 and make the new byte the head.
REQ-030 SHALL ignore a pop while empty.
REQ-031 SHALL give set priority over clear_i when a flag's set event and clear_i occur in the same cycle.

Reset
REQ-032 SHALL, on reset=1 at a clock edge: set the FSM to IDLE, cnt and bit index to 0, FIFO to empty, valid_o=0, level_o=0, frame_err_o=0, overrun_o=0, data_o=0, and both synchronizer flops to 1.
REQ-033 SHALL treat reset asserted mid-frame as discarding the partial byte; after release, the receiver waits for a new falling edge on rx_s.

Verification
REQ-034 SHALL cover: div=8, frame 0xA5 with ready_i=0 -> valid_o=1, data_o=0xA5, level_o=1, and no flags.
REQ-035 SHALL cover: div=8, uart_rx low for 3 cycles then high -> no push and no flags; the FSM returns to IDLE.
REQ-036 SHALL cover: div=16, frame 0x3C with stop bit 0 -> frame_err_o=1 and level_o=0; a clear_i pulse -> frame_err_o=0.
REQ-037 SHALL cover: ready_i=0, frames 0x11, 0x22, 0x33 -> level_o=2, overrun_o=1; pops return 0x11 then 0x22.
REQ-038 SHALL cover: FIFO full with ready_i=1 held while frame 0x44 completes -> no overrun and level_o=2; pops return the old second byte, then 0x44.
REQ-039 SHALL cover: reset pulsed after data bit 3 of a frame, then frame 0x5A sent -> only 0x5A is received.
